branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
//   Program-counter sequencer that owns the conditional unit. Fetches instruction bytes
//   from program memory over a req/ack port and forwards ordinary instructions to the
//   execute stage. For conditional jumps it fetches the target byte, drives the
//   conditional unit, waits for its registered result, then loads PC with target or PC+2.
//   Sits between program memory, the accumulator and the execute stage.
// PARAMETERS
//   ADDR_W       8  program-address width; PC and all address arithmetic wrap mod 2**ADDR_W
//   COND_LATENCY 1  clocks from cond_opcode/cond_operand stable to cond_result valid
// PORTS
//   clock         in   1       system clock, all logic on posedge
//   reset         in   1       synchronous, active-high
//   mem_addr      out  ADDR_W  program-memory byte address
//   mem_req       out  1       read request; held with stable mem_addr until mem_ack
//   mem_ack       in   1       read complete; mem_data valid in the same cycle
//   mem_data      in   8       program byte
//   acc_value     in   8       signed accumulator, source of the conditional operand
//   cond_opcode   out  3       to conditional unit (000 never .. 111 >=0)
//   cond_operand  out  8       to conditional unit, signed
//   cond_result   in   1       from conditional unit (registered inside the unit)
//   exec_valid    out  1       instruction available to execute stage
//   exec_instr    out  8       instruction byte, stable while exec_valid
//   exec_ready    in   1       execute stage accepts; transfer = exec_valid & exec_ready
//   pc            out  ADDR_W  current program counter
//   branch_taken  out  1       one-cycle pulse when a conditional jump loads PC
// BEHAVIOUR
//   Reset: pc=0, mem_req=0, mem_addr=0, exec_valid=0, exec_instr=0, cond_opcode=000,
//     cond_operand=0, branch_taken=0, state=FETCH. Reset mid-operation abandons all work;
//     no pulse or exec transfer completes in the reset cycle.
//   FETCH: mem_req=1, mem_addr=pc. On mem_ack latch byte as IR and go to DECODE.
//     mem_ack while mem_req=0 is ignored.
//   DECODE (1 cycle): IR[7:3]==5'b11000 -> conditional, go TARGET; otherwise go ISSUE.
//   ISSUE: exec_valid=1, exec_instr=IR. On exec_valid&exec_ready: pc<=pc+1, exec_valid
//     drops next cycle, go FETCH. exec_ready while exec_valid=0 is ignored.
//   TARGET: mem_req=1, mem_addr=pc+1 (wraps, 0xFF->0x00). On mem_ack latch TGT,
//     register cond_opcode<=IR[2:0] and cond_operand<=acc_value (sampled that cycle),
//     go EVAL.
//   EVAL: cond_opcode/cond_operand held stable for COND_LATENCY+1 cycles; cond_result
//     sampled in the last EVAL cycle. Result 1 -> pc<=TGT, branch_taken=1 for the
//     following cycle. Result 0 -> pc<=pc+2 (wraps). Then cond_opcode<=000, go FETCH.
//   Opcodes 000/100 still go through EVAL, so branch latency is uniform.
//   Latency, zero-wait memory: plain instruction fetch->issue = 2 cycles; conditional
//     FETCH+DECODE+TARGET+EVAL = 3+COND_LATENCY+1 cycles before next FETCH.
//   pc changes only on an exec transfer or on EVAL completion.
// STRUCTURE
//   Package cpu_ctrl_pkg: state enum {FETCH,DECODE,ISSUE,TARGET,EVAL};
//     MODE_COND=2'b11; COND_NEVER=3'b000, COND_ALWAYS=3'b100 and the other six opcodes.
//   Sub-module mem_fetch_port: req/ack holding register that keeps mem_req/mem_addr
//     stable and captures mem_data; the FSM and PC logic stay in branch_sequencer.
//   Bench instantiates the real conditional unit behind cond_* with COND_LATENCY=1.
// TESTING
//   1 Hold reset 2 cycles, release -> first cycle mem_req=1, mem_addr=0x00, all
//     other outputs at reset values.
//   2 mem[0x00]=0x12, ack after 2 waits, exec_ready low 3 cycles -> exec_valid held with
//     exec_instr=0x12 throughout; pc=0x01 after transfer.
//   3 pc=0x04, mem[0x04]=0xC2 (<0), mem[0x05]=0x40, acc=0x80 -> cond_opcode=010,
//     cond_operand=0x80 stable for 2 cycles, branch_taken pulse, pc=0x40.
//   4 Same as 3 with acc=0x00 -> no pulse, pc=0x06; with acc=0x00, IR=0xC1 (==0) -> pc=0x40.
//   5 pc=0xFF, mem[0xFF]=0xC4 (always), mem[0x00]=0x10 -> target read at 0x00, pc=0x10.
//     Same with 0xC0 (never) -> pc=0x01.
//   6 Assert reset during EVAL and during ISSUE with exec_ready=1 -> next cycle mem_req=0,
//     cond_opcode=000, pc=0x00, no branch_taken, no exec transfer counted.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the branch sequencer: FSM states, instruction
// mode bits and the conditional-unit opcode set.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    ISSUE  = 3'd2,
    TARGET = 3'd3,
    EVAL   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_COND     = 2'b11;
  localparam logic [2:0] COND_JUMP_SUB = 3'b000;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_LT     = 3'b010;
  localparam logic [2:0] COND_LE     = 3'b011;
  localparam logic [2:0] COND_ALWAYS = 3'b100;
  localparam logic [2:0] COND_NE     = 3'b101;
  localparam logic [2:0] COND_GT     = 3'b110;
  localparam logic [2:0] COND_GE     = 3'b111;

  // Conditional jumps are encoded as 11_000_ccc.
  function automatic logic is_cond_jump(input logic [7:0] instr);
    return (instr[7:6] == MODE_COND) && (instr[5:3] == COND_JUMP_SUB);
  endfunction

  // Reference meaning of each opcode against a signed operand.
  function automatic logic cond_holds(input logic [2:0] opcode, input logic [7:0] operand);
    logic neg;
    logic zero;
    neg  = operand[7];
    zero = (operand == 8'h00);
    case (opcode)
      COND_NEVER:  return 1'b0;
      COND_EQ:     return zero;
      COND_LT:     return neg;
      COND_LE:     return neg | zero;
      COND_ALWAYS: return 1'b1;
      COND_NE:     return ~zero;
      COND_GT:     return ~neg & ~zero;
      COND_GE:     return ~neg;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_sequencer_mem_fetch_port.sv
// Program-memory request holder: keeps mem_req/mem_addr stable until mem_ack
// and captures the returned byte.
module mem_fetch_port
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_next,
  input  logic [ADDR_W-1:0] addr_next,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              done,
  output logic [7:0]        rdata
);

  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        rdata_r;

  assign done     = req_r & mem_ack;
  assign mem_req  = req_r;
  assign mem_addr = addr_r;
  assign rdata    = rdata_r;

  // Hold an outstanding request; otherwise load the request for the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_r   <= 1'b0;
      addr_r  <= '0;
      rdata_r <= 8'h00;
    end else begin
      if (req_r && !mem_ack) begin
        req_r  <= req_r;
        addr_r <= addr_r;
      end else begin
        req_r  <= req_next;
        addr_r <= addr_next;
      end
      if (done) begin
        rdata_r <= mem_data;
      end
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: fetches instructions, issues plain ones to the
// execute stage and resolves conditional jumps through the conditional unit.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int COND_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  input  logic [7:0]        acc_value,
  output logic [2:0]        cond_opcode,
  output logic [7:0]        cond_operand,
  input  logic              cond_result,
  output logic              exec_valid,
  output logic [7:0]        exec_instr,
  input  logic              exec_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              branch_taken
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2'd2);
  localparam logic [3:0]        EVAL_LAST = 4'(COND_LATENCY);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [7:0]        ir_r;
  logic              exec_valid_r;
  logic [2:0]        cond_opcode_r;
  logic [7:0]        cond_operand_r;
  logic              branch_taken_r;
  logic [3:0]        eval_cnt_r;

  logic              done_s;
  logic [7:0]        rdata_s;
  logic              req_next_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic              xfer_s;
  logic              eval_last_s;

  assign xfer_s      = exec_valid_r & exec_ready;
  assign eval_last_s = (eval_cnt_r == EVAL_LAST);

  mem_fetch_port #(.ADDR_W(ADDR_W)) u_port (
    .clock     (clock),
    .reset     (reset),
    .req_next  (req_next_s),
    .addr_next (addr_next_s),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .done      (done_s),
    .rdata     (rdata_s)
  );

  // Next state, next PC and the memory request that the next state needs.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    case (state_r)
      FETCH: begin
        if (done_s) state_s = DECODE;
        else        state_s = FETCH;
      end
      DECODE: begin
        if (is_cond_jump(rdata_s)) state_s = TARGET;
        else                       state_s = ISSUE;
      end
      ISSUE: begin
        if (xfer_s) begin
          state_s = FETCH;
          pc_s    = pc_r + PC_ONE;
        end else begin
          state_s = ISSUE;
        end
      end
      TARGET: begin
        if (done_s) state_s = EVAL;
        else        state_s = TARGET;
      end
      EVAL: begin
        if (eval_last_s) begin
          state_s = FETCH;
          // In EVAL the port still holds the target byte.
          if (cond_result) pc_s = ADDR_W'(rdata_s);
          else             pc_s = pc_r + PC_TWO;
        end else begin
          state_s = EVAL;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase

    req_next_s = (state_s == FETCH) || (state_s == TARGET);
    if (state_s == TARGET) addr_next_s = pc_s + PC_ONE;
    else                   addr_next_s = pc_s;
  end

  // Sequencer state, PC, instruction register and conditional-unit drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= FETCH;
      pc_r           <= '0;
      ir_r           <= 8'h00;
      exec_valid_r   <= 1'b0;
      cond_opcode_r  <= COND_NEVER;
      cond_operand_r <= 8'h00;
      branch_taken_r <= 1'b0;
      eval_cnt_r     <= 4'd0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      exec_valid_r   <= (state_s == ISSUE);
      branch_taken_r <= (state_r == EVAL) && eval_last_s && cond_result;
      if (state_r == DECODE) begin
        ir_r <= rdata_s;
      end
      if ((state_r == TARGET) && done_s) begin
        cond_opcode_r  <= ir_r[2:0];
        cond_operand_r <= acc_value;
      end else if ((state_r == EVAL) && eval_last_s) begin
        cond_opcode_r  <= COND_NEVER;
      end
      if ((state_r == EVAL) && !eval_last_s) eval_cnt_r <= eval_cnt_r + 4'd1;
      else                                   eval_cnt_r <= 4'd0;
    end
  end

  assign pc           = pc_r;
  assign exec_valid   = exec_valid_r;
  assign exec_instr   = ir_r;
  assign cond_opcode  = cond_opcode_r;
  assign cond_operand = cond_operand_r;
  assign branch_taken = branch_taken_r;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with a program-memory responder and a
// registered conditional unit (one-cycle latency) behind the cond_* port.
module tb_branch_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] acc_value;
  logic [2:0] cond_opcode;
  logic [7:0] cond_operand;
  logic       cond_result = 1'b0;
  logic       exec_valid;
  logic [7:0] exec_instr;
  logic       exec_ready;
  logic [7:0] pc;
  logic       branch_taken;

  logic [7:0] mem [0:255];
  int         ack_wait = 0;
  int         wait_cnt = 0;
  int         xfer_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  branch_sequencer #(.ADDR_W(8), .COND_LATENCY(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .acc_value    (acc_value),
    .cond_opcode  (cond_opcode),
    .cond_operand (cond_operand),
    .cond_result  (cond_result),
    .exec_valid   (exec_valid),
    .exec_instr   (exec_instr),
    .exec_ready   (exec_ready),
    .pc           (pc),
    .branch_taken (branch_taken)
  );

  always #5 clock = ~clock;

  // Memory responder: ack after ack_wait idle cycles of an outstanding request.
  always @(negedge clock) begin
    if (mem_req && !reset) begin
      if (wait_cnt >= ack_wait) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
        wait_cnt = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Conditional unit: registered result, opcode 000 never .. 111 >=0.
  always @(posedge clock) begin
    case (cond_opcode)
      3'b000:  cond_result <= 1'b0;
      3'b001:  cond_result <= (cond_operand == 8'h00);
      3'b010:  cond_result <= cond_operand[7];
      3'b011:  cond_result <= cond_operand[7] || (cond_operand == 8'h00);
      3'b100:  cond_result <= 1'b1;
      3'b101:  cond_result <= (cond_operand != 8'h00);
      3'b110:  cond_result <= !cond_operand[7] && (cond_operand != 8'h00);
      default: cond_result <= !cond_operand[7];
    endcase
  end

  always @(posedge clock) begin
    if (!reset && exec_valid && exec_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic wait_pc(input logic [7:0] val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pc === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_op(input logic [2:0] val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cond_opcode === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; exec_ready = 1'b0; acc_value = 8'h00; ack_wait = 2;
    @(negedge clock); @(negedge clock);
    checks++; if (mem_req !== 1'b0 || pc !== 8'h00) begin failures++; $display("FAIL rst_hold req=%b pc=%h exp req=0 pc=00", mem_req, pc); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", mem_addr); end
    checks++; if (exec_valid !== 1'b0 || exec_instr !== 8'h00 || branch_taken !== 1'b0) begin failures++; $display("FAIL rst_exec v=%b i=%h bt=%b exp 0/00/0", exec_valid, exec_instr, branch_taken); end
    checks++; if (cond_opcode !== 3'b000 || cond_operand !== 8'h00 || pc !== 8'h00) begin failures++; $display("FAIL rst_cond op=%b opd=%h pc=%h exp 000/00/00", cond_opcode, cond_operand, pc); end
  endtask

  task automatic test_issue_stall();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (exec_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (!ok) begin failures++; $display("FAIL issue_valid timeout got=%b exp=1", exec_valid); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (exec_valid !== 1'b1 || exec_instr !== 8'h12) begin failures++; $display("FAIL issue_hold%0d v=%b i=%h exp 1/12", i, exec_valid, exec_instr); end
      @(negedge clock);
    end
    exec_ready = 1'b1;
    @(negedge clock);
    checks++; if (pc !== 8'h01) begin failures++; $display("FAIL issue_pc got=%h exp=01", pc); end
    checks++; if (exec_valid !== 1'b0) begin failures++; $display("FAIL issue_drop got=%b exp=0", exec_valid); end
    ack_wait = 0;
    wait_pc(8'h04, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL walk_pc got=%h exp=04", pc); end
  endtask

  task automatic test_branch_lt_taken();
    bit ok;
    wait_op(3'b010, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lt_op timeout got=%b exp=010", cond_opcode); end
    checks++; if (cond_operand !== 8'h80 || branch_taken !== 1'b0) begin failures++; $display("FAIL lt_eval1 opd=%h bt=%b exp 80/0", cond_operand, branch_taken); end
    @(negedge clock);
    checks++; if (cond_opcode !== 3'b010 || cond_operand !== 8'h80 || pc !== 8'h04) begin failures++; $display("FAIL lt_eval2 op=%b opd=%h pc=%h exp 010/80/04", cond_opcode, cond_operand, pc); end
    @(negedge clock);
    checks++; if (branch_taken !== 1'b1 || pc !== 8'h40) begin failures++; $display("FAIL lt_taken bt=%b pc=%h exp 1/40", branch_taken, pc); end
    checks++; if (cond_opcode !== 3'b000) begin failures++; $display("FAIL lt_opclr got=%b exp=000", cond_opcode); end
    acc_value = 8'h00;
    @(negedge clock);
    checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL lt_pulse got=%b exp=0", branch_taken); end
  endtask

  task automatic test_branch_not_taken_and_eq();
    bit ok;
    wait_pc(8'h04, 30, ok);
    checks++; if (!ok || branch_taken !== 1'b1) begin failures++; $display("FAIL back_jump pc=%h bt=%b exp 04/1", pc, branch_taken); end
    mem[8'h41] = 8'hFF;
    wait_op(3'b010, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nt_op timeout got=%b exp=010", cond_opcode); end
    @(negedge clock); @(negedge clock);
    checks++; if (pc !== 8'h06 || branch_taken !== 1'b0) begin failures++; $display("FAIL nt_pc pc=%h bt=%b exp 06/0", pc, branch_taken); end
    wait_op(3'b001, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL eq_op timeout got=%b exp=001", cond_opcode); end
    @(negedge clock); @(negedge clock);
    checks++; if (pc !== 8'h40 || branch_taken !== 1'b1) begin failures++; $display("FAIL eq_pc pc=%h bt=%b exp 40/1", pc, branch_taken); end
  endtask

  task automatic test_wrap();
    bit ok;
    bit saw00;
    mem[8'h00] = 8'h10;
    wait_pc(8'hFF, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_reach pc=%h exp=ff", pc); end
    saw00 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pc !== 8'hFF) break;
      if (mem_req === 1'b1 && mem_addr === 8'h00) saw00 = 1'b1;
      @(negedge clock);
    end
    checks++; if (saw00 !== 1'b1) begin failures++; $display("FAIL wrap_tgt_addr saw00=%b exp=1", saw00); end
    checks++; if (pc !== 8'h10 || branch_taken !== 1'b1) begin failures++; $display("FAIL wrap_always pc=%h bt=%b exp 10/1", pc, branch_taken); end
    mem[8'hFF] = 8'hC0;
    wait_pc(8'hFF, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_reach2 pc=%h exp=ff", pc); end
    for (int i = 0; i < 20; i++) begin
      if (pc !== 8'hFF) break;
      @(negedge clock);
    end
    checks++; if (pc !== 8'h01 || branch_taken !== 1'b0) begin failures++; $display("FAIL wrap_never pc=%h bt=%b exp 01/0", pc, branch_taken); end
    acc_value = 8'h05;
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int xfers;
    int steps;
    wait_op(3'b111, 80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ge_op timeout got=%b exp=111", cond_opcode); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (mem_req !== 1'b0 || cond_opcode !== 3'b000) begin failures++; $display("FAIL rst_eval req=%b op=%b exp 0/000", mem_req, cond_opcode); end
    checks++; if (pc !== 8'h00 || branch_taken !== 1'b0) begin failures++; $display("FAIL rst_eval_pc pc=%h bt=%b exp 00/0", pc, branch_taken); end
    exec_ready = 1'b0;
    reset = 1'b0;
    steps = 0;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      steps++;
      if (exec_valid === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || steps != 3) begin failures++; $display("FAIL issue_latency steps=%0d exp=3", steps); end
    xfers = xfer_cnt;
    reset = 1'b1;
    exec_ready = 1'b1;
    @(negedge clock);
    checks++; if (pc !== 8'h00 || exec_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rst_issue pc=%h v=%b req=%b exp 00/0/0", pc, exec_valid, mem_req); end
    checks++; if (xfer_cnt != xfers) begin failures++; $display("FAIL rst_xfer got=%0d exp=%0d", xfer_cnt, xfers); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h00] = 8'h12;
    mem[8'h04] = 8'hC2; mem[8'h05] = 8'h40;
    mem[8'h06] = 8'hC1; mem[8'h07] = 8'h40;
    mem[8'h08] = 8'hC7; mem[8'h09] = 8'h30;
    mem[8'h10] = 8'hC4; mem[8'h11] = 8'hFF;
    mem[8'h40] = 8'hC4; mem[8'h41] = 8'h04;
    mem[8'hFF] = 8'hC4;
    test_reset();
    acc_value = 8'h80;
    test_issue_stall();
    test_branch_lt_taken();
    test_branch_not_taken_and_eq();
    test_wrap();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
